dp_ram_be_init: RTL

Single-clock true dual-port RAM that succeeds the basic dual-port RAM.
- Adds per-byte write enables, a selectable read-during-write mode and a configurable read latency.
- Adds cross-port collision detection and a reset-triggered memory initialisation state machine.
- Used as the shared storage primitive behind packet buffers and descriptor tables, where deterministic contents after reset are required.

---
 rtl/dp_ram_pkg.sv | 49 ++++
 rtl/dp_ram_be_init_rd_pipe.sv | 65 ++++++
 rtl/dp_ram_be_init.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram_be_init byte-enable dual-port RAM.
// The lane helpers work on a fixed maximum width (MAX_DW data bits,
// MAX_LANES lanes); callers zero-extend in and truncate out.
package dp_ram_pkg;

  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  localparam int unsigned MAX_DW    = 256;
  localparam int unsigned MAX_LANES = 32;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef logic [MAX_DW-1:0]    word_t;
  typedef logic [MAX_LANES-1:0] lanes_t;

  // Replace every lane of old_word whose enable bit is set with new_word.
  function automatic word_t lane_merge(input word_t       old_word,
                                       input word_t       new_word,
                                       input lanes_t      lane_en,
                                       input int unsigned lane_width,
                                       input int unsigned num_lanes);
    word_t res;
    res = old_word;
    for (int unsigned j = 0; j < MAX_DW; j++) begin
      if (j < lane_width * num_lanes) begin
        if (lane_en[j / lane_width]) begin
          res[j] = new_word[j];
        end
      end
    end
    return res;
  endfunction

  // One even-parity bit per lane: XOR of all bits in the lane.
  function automatic lanes_t even_parity(input word_t       data,
                                         input int unsigned lane_width,
                                         input int unsigned num_lanes);
    lanes_t par;
    par = '0;
    for (int unsigned j = 0; j < MAX_DW; j++) begin
      if (j < lane_width * num_lanes) begin
        par[j / lane_width] = par[j / lane_width] ^ data[j];
      end
    end
    return par;
  endfunction

endpackage

// File: rtl/dp_ram_be_init_rd_pipe.sv
// Per-port output stage: RD_LATENCY-deep register chain carrying the
// valid strobe, read word and parity-error flag. Data stages only load
// when their incoming valid is set, so dout holds between strobes.
module dp_ram_rd_pipe
  import dp_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_perr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_perr
);

  logic [RD_LATENCY-1:0] valid_q, valid_d;
  logic [RD_LATENCY-1:0] perr_q, perr_d;
  logic [DATA_WIDTH-1:0] data_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] data_d [RD_LATENCY];

  logic [RD_LATENCY:0]   valid_chain;
  logic [RD_LATENCY:0]   perr_chain;
  logic [DATA_WIDTH-1:0] data_src [RD_LATENCY+1];

  // Shift valid/perr one stage per cycle; load data only with its valid.
  always_comb begin
    valid_chain = {valid_q, in_valid};
    perr_chain  = {perr_q, in_valid & in_perr};
    data_src[0] = in_data;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      data_src[i+1] = data_q[i];
    end
    valid_d = valid_chain[RD_LATENCY-1:0];
    perr_d  = perr_chain[RD_LATENCY-1:0];
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      data_d[i] = valid_chain[i] ? data_src[i] : data_q[i];
    end
  end

  // Pipeline registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      perr_q  <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      perr_q  <= perr_d;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[RD_LATENCY-1];
  assign out_data  = data_q[RD_LATENCY-1];
  assign out_perr  = perr_q[RD_LATENCY-1];

endmodule

// File: rtl/dp_ram_be_init.sv
// Single-clock true dual-port RAM with byte enables, read-during-write
// mode select, 1/2-cycle read latency, same-address collision strobe and
// a reset-triggered sweep writing INIT_VALUE to every word.
// Optional per-lane even parity: define DP_RAM_PARITY_EN.
module dp_ram_be_init
  import dp_ram_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter int unsigned           BYTE_WIDTH = 8,
  parameter int unsigned           RD_LATENCY = 1,
  parameter int unsigned           RDW_MODE   = RDW_READ_FIRST,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_busy,
  input  logic                           en_a,
  input  logic                           wr_en_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]          addr_a,
  input  logic [DATA_WIDTH-1:0]          din_a,
  output logic [DATA_WIDTH-1:0]          dout_a,
  output logic                           valid_a,
  output logic                           par_err_a,
  input  logic                           en_b,
  input  logic                           wr_en_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]          addr_b,
  input  logic [DATA_WIDTH-1:0]          din_b,
  output logic [DATA_WIDTH-1:0]          dout_b,
  output logic                           valid_b,
  output logic                           par_err_b,
  output logic                           collision
);

  localparam int unsigned NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  init_we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc_a, acc_b, we_a, we_b, same_addr, coll_now;
  logic [DATA_WIDTH-1:0] old_a, old_b, base_a, wdata_a, wdata_b;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b;
  logic                  perr_a, perr_b;

  logic [RD_LATENCY-1:0] coll_q, coll_d;
  logic [RD_LATENCY:0]   coll_chain;

  // FSM state register: reset restarts the sweep at address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next state: advance the pointer in INIT, leave after the last word.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // FSM outputs.
  always_comb begin
    init_busy = (state_q == ST_INIT);
    init_we   = (state_q == ST_INIT) && !rst;
  end

  // Request acceptance, lane merges and returned read words.
  // A same-address dual write merges B onto the old word first and then
  // A on top, so lanes enabled on both ports end up with A data.
  always_comb begin
    acc_a     = en_a && (state_q == ST_RUN) && !rst;
    acc_b     = en_b && (state_q == ST_RUN) && !rst;
    we_a      = acc_a && wr_en_a;
    we_b      = acc_b && wr_en_b;
    same_addr = (addr_a == addr_b);
    coll_now  = acc_a && acc_b && same_addr && (we_a || we_b);
    old_a     = mem_q[addr_a];
    old_b     = mem_q[addr_b];
    wdata_b   = DATA_WIDTH'(lane_merge(word_t'(old_b), word_t'(din_b),
                                       lanes_t'(be_b), BYTE_WIDTH, NUM_BYTES));
    base_a    = (we_b && same_addr) ? wdata_b : old_a;
    wdata_a   = DATA_WIDTH'(lane_merge(word_t'(base_a), word_t'(din_a),
                                       lanes_t'(be_a), BYTE_WIDTH, NUM_BYTES));
    rdata_a   = old_a;
    rdata_b   = old_b;
    if (RDW_MODE == RDW_WRITE_FIRST) begin
      if (we_a) begin
        rdata_a = DATA_WIDTH'(lane_merge(word_t'(old_a), word_t'(din_a),
                                         lanes_t'(be_a), BYTE_WIDTH, NUM_BYTES));
      end
      if (we_b) begin
        rdata_b = wdata_b;
      end
    end
  end

  // Storage array: init sweep has priority, then B, then A (A wins overlap).
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[ptr_q] <= INIT_VALUE;
    end else begin
      if (we_b) begin
        mem_q[addr_b] <= wdata_b;
      end
      if (we_a) begin
        mem_q[addr_a] <= wdata_a;
      end
    end
  end

`ifdef DP_RAM_PARITY_EN
  logic [NUM_BYTES-1:0] par_q [DEPTH];
  logic [NUM_BYTES-1:0] init_par, wpar_a, wpar_b, base_par_a;

  // Parity bits follow the same lane merge as the data they protect.
  always_comb begin
    init_par   = NUM_BYTES'(even_parity(word_t'(INIT_VALUE), BYTE_WIDTH, NUM_BYTES));
    wpar_b     = NUM_BYTES'(lane_merge(word_t'(par_q[addr_b]),
                   word_t'(even_parity(word_t'(din_b), BYTE_WIDTH, NUM_BYTES)),
                   lanes_t'(be_b), 1, NUM_BYTES));
    base_par_a = (we_b && same_addr) ? wpar_b : par_q[addr_a];
    wpar_a     = NUM_BYTES'(lane_merge(word_t'(base_par_a),
                   word_t'(even_parity(word_t'(din_a), BYTE_WIDTH, NUM_BYTES)),
                   lanes_t'(be_a), 1, NUM_BYTES));
    perr_a     = |(par_q[addr_a] ^
                   NUM_BYTES'(even_parity(word_t'(old_a), BYTE_WIDTH, NUM_BYTES)));
    perr_b     = |(par_q[addr_b] ^
                   NUM_BYTES'(even_parity(word_t'(old_b), BYTE_WIDTH, NUM_BYTES)));
  end

  // Parity array, written alongside the data array.
  always_ff @(posedge clk) begin
    if (init_we) begin
      par_q[ptr_q] <= init_par;
    end else begin
      if (we_b) begin
        par_q[addr_b] <= wpar_b;
      end
      if (we_a) begin
        par_q[addr_a] <= wpar_a;
      end
    end
  end
`else
  // No parity storage: error flags are constant zero.
  always_comb begin
    perr_a = 1'b0;
    perr_b = 1'b0;
  end
`endif

  // Collision strobe delayed to line up with valid_a/valid_b.
  always_comb begin
    coll_chain = {coll_q, coll_now};
    coll_d     = coll_chain[RD_LATENCY-1:0];
  end

  // Collision delay registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q[RD_LATENCY-1];

  dp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_a),
    .in_data   (rdata_a),
    .in_perr   (perr_a),
    .out_valid (valid_a),
    .out_data  (dout_a),
    .out_perr  (par_err_a)
  );

  dp_ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (acc_b),
    .in_data   (rdata_b),
    .in_perr   (perr_b),
    .out_valid (valid_b),
    .out_data  (dout_b),
    .out_perr  (par_err_b)
  );

endmodule
